// File: rtl/piezo_tone_decoder.sv
// piezo_tone_decoder: locks onto C4..C5 tones by half-period measurement, flags off-table tones and silence
module piezo_tone_decoder #(
    parameter int TOL         = 20,
    parameter int STABLE      = 3,
    parameter int SILENCE_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tone_in,
    output logic [2:0] note_idx,
    output logic       note_valid,
    output logic       note_locked,
    output logic       note_err,
    output logic       silence
);
    typedef enum logic [1:0] {SILENT, ACQUIRE, LOCKED} state_t;
    localparam logic [15:0] NOM [0:7] = '{16'd1912, 16'd1704, 16'd1518, 16'd1433,
                                          16'd1277, 16'd1137, 16'd1013, 16'd957};
    localparam logic [15:0] SIL16 = 16'(SILENCE_CYC);
    localparam logic signed [16:0] TOLS = 17'(TOL);
    localparam logic [2:0] STB = 3'(STABLE);
    state_t state, nstate;
    logic s1, s2, d, tgl, timeout, hit, nvalid, nerr;
    logic [15:0] hp_cnt;
    logic [2:0] cand, run, midx, ncand, nrun, nidx, erun, arun;
    logic signed [16:0] diff;
    always_ff @(posedge clk or posedge rst)
        if (rst) {s1, s2, d} <= '0;
        else {s1, s2, d} <= {tone_in, s1, s2};
    assign tgl = s2 ^ d;
    always_ff @(posedge clk or posedge rst)
        if (rst) hp_cnt <= '0;
        else if (tgl) hp_cnt <= 16'd1;
        else if (hp_cnt < SIL16) hp_cnt <= hp_cnt + 16'd1;
    // timeout fires on the cycle the counter would reach the limit, so a coincident edge wins
    assign timeout = !tgl && hp_cnt == SIL16 - 16'd1;
    always_comb begin
        hit  = 1'b0;
        midx = 3'd0;
        diff = '0;
        for (int i = 0; i < 8; i++) begin
            diff = $signed({1'b0, hp_cnt}) - $signed({1'b0, NOM[i]});
            if (diff <= TOLS && diff >= -TOLS) begin
                hit  = 1'b1;
                midx = 3'(i);
            end
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= SILENT;
            cand       <= '0;
            run        <= '0;
            note_idx   <= '0;
            note_valid <= 1'b0;
            note_err   <= 1'b0;
        end else begin
            state      <= nstate;
            cand       <= ncand;
            run        <= nrun;
            note_idx   <= nidx;
            note_valid <= nvalid;
            note_err   <= nerr;
        end
    // leaving LOCKED restarts the run count, so a new note needs STABLE fresh matches
    assign erun = state == ACQUIRE ? run : 3'd0;
    assign arun = (midx == cand && erun != 3'd0) ? erun + 3'd1 : 3'd1;
    always_comb begin
        nstate = state;
        ncand  = cand;
        nrun   = run;
        nidx   = note_idx;
        nvalid = 1'b0;
        nerr   = 1'b0;
        if (state == SILENT) begin
            if (tgl) begin
                nstate = ACQUIRE;
                nrun   = 3'd0;
            end
        end else if (tgl) begin
            if (!hit) begin
                nstate = ACQUIRE;
                nrun   = 3'd0;
                nerr   = 1'b1;
            end else if (!(state == LOCKED && midx == note_idx)) begin
                ncand  = midx;
                nrun   = arun;
                nstate = arun >= STB ? LOCKED : ACQUIRE;
                nidx   = arun >= STB ? midx : note_idx;
                nvalid = arun >= STB;
            end
        end else if (timeout) nstate = SILENT;
    end
    always_comb begin
        silence     = state == SILENT;
        note_locked = state == LOCKED;
    end
endmodule

// File: tb/tb_piezo_tone_decoder.sv
// tb_piezo_tone_decoder: directed tone stimulus with a strobe scoreboard for piezo_tone_decoder
module tb_piezo_tone_decoder;
    localparam int SIL = 2048;
    logic clk = 1'b0, rst = 1'b1, tone_in = 1'b0;
    logic [2:0] note_idx;
    logic note_valid, note_locked, note_err, silence;
    int total = 0, bad = 0, cyc = 0, last_t = 0, nv = 0, ne = 0;
    int hp [8] = '{1912, 1704, 1518, 1433, 1277, 1137, 1013, 957};
    typedef struct {int c; int k; int i;} ev_t;
    ev_t q[$];
    ev_t mon_e;
    piezo_tone_decoder #(.TOL(20), .STABLE(3), .SILENCE_CYC(SIL)) dut (
        .clk(clk), .rst(rst), .tone_in(tone_in), .note_idx(note_idx),
        .note_valid(note_valid), .note_locked(note_locked), .note_err(note_err), .silence(silence));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    // toggle after n cycles; k: 0 none, 1 note_valid, 2 note_err expected 3 cycles later
    task automatic tg(input int n, input int k, input int i);
        repeat (n) @(posedge clk);
        #1 tone_in = ~tone_in;
        last_t = cyc;
        if (k != 0) q.push_back(ev_t'{cyc + 3, k, i});
    endtask
    task automatic idle_check(input string nm, input int n);
        int viol = 0;
        repeat (n) begin
            @(negedge clk);
            if (silence !== 1'b1 || note_locked !== 1'b0 || note_valid !== 1'b0 ||
                note_err !== 1'b0 || note_idx !== 3'd0) viol++;
        end
        chk(nm, viol, 0);
    endtask
    always @(negedge clk)
        if (note_valid || note_err) begin
            if (note_valid) nv++;
            if (note_err) ne++;
            if (q.size() == 0) chk("unexpected_strobe", note_valid ? 1 : 2, 0);
            else begin
                mon_e = q.pop_front();
                chk("strobe_kind", note_valid ? 1 : 2, mon_e.k);
                chk("strobe_idx", int'(note_idx), mon_e.i);
                chk("strobe_cycle", cyc, mon_e.c);
                if (note_valid) chk("locked_with_valid", int'(note_locked), 1);
            end
        end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_silence", int'(silence), 1);
        chk("rst_locked", int'(note_locked), 0);
        chk("rst_idx", int'(note_idx), 0);
        chk("rst_strobes", int'(note_valid | note_err), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle_check("idle_after_rst", 1000);
        for (int i = 0; i < 8; i++)
            for (int e = 1; e <= (i == 0 ? 5 : 3); e++)
                tg(hp[i], e == (i == 0 ? 4 : 3) ? 1 : 0, i);
        repeat (10) @(negedge clk);
        chk("scale_locked", int'(note_locked), 1);
        chk("scale_idx", int'(note_idx), 7);
        chk("scale_valid_count", nv, 8);
        chk("scale_err_count", ne, 0);
        repeat (SIL + 10) @(negedge clk);
        chk("scale_silent", int'(silence), 1);
        chk("scale_unlocked", int'(note_locked), 0);
        chk("scale_idx_held", int'(note_idx), 7);
        repeat (3) tg(1932, 0, 0);
        tg(1932, 1, 0);
        repeat (2) tg(1933, 2, 0);
        repeat (5) @(negedge clk);
        chk("tol_hi_miss_unlocked", int'(note_locked), 0);
        repeat (2) tg(937, 0, 7);
        tg(937, 1, 7);
        repeat (2) tg(936, 2, 7);
        repeat (5) @(negedge clk);
        chk("tol_lo_miss_unlocked", int'(note_locked), 0);
        repeat (SIL + 10) @(negedge clk);
        repeat (3) tg(1277, 0, 4);
        tg(1277, 1, 4);
        do @(negedge clk); while (cyc < last_t + 1 + SIL);
        chk("sil_before_silence", int'(silence), 0);
        chk("sil_before_locked", int'(note_locked), 1);
        @(negedge clk);
        chk("sil_at_silence", int'(silence), 1);
        chk("sil_at_locked", int'(note_locked), 0);
        chk("sil_idx_held", int'(note_idx), 4);
        repeat (10) @(negedge clk);
        repeat (3) tg(1518, 0, 2);
        tg(1518, 1, 2);
        tg(1600, 2, 2);
        repeat (5) @(posedge clk);
        #1 chk("glitch_unlocked", int'(note_locked), 0);
        tg(1513, 0, 2);
        tg(1518, 0, 2);
        tg(1518, 1, 2);
        repeat (100) @(posedge clk);
        #1 chk("glitch_relocked", int'(note_locked), 1);
        chk("glitch_idx", int'(note_idx), 2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_rst_silence", int'(silence), 1);
        chk("async_rst_locked", int'(note_locked), 0);
        chk("async_rst_idx", int'(note_idx), 0);
        tone_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle_check("idle_after_midlock_rst", 1000);
        repeat (10) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/piezo_tone_decoder.md
# piezo_tone_decoder

Measures the half-period of a square-wave tone on a single input and identifies which of the eight scale notes C4–C5 it is. It accepts the toggle waveform produced by the team's 1 MHz piezo melody generator, which holds each note for about 0.5 s. It reports each newly locked note with a one-cycle strobe, and flags off-table tones and silence. It sits on the loopback and self-test path: the piezo drive line feeds back into `tone_in`.

## Interface
- `TOL`, 20 — match tolerance in clk cycles; must be < 28 (half the closest nominal gap, 56).
- `STABLE`, 3 — consecutive same-note half-periods required to lock; range 1–7.
- `SILENCE_CYC`, 4096 — cycles without an edge before the input is declared silent; must be > 1957.
- `clk`  in  1  1 MHz system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `tone_in`  in  1  tone waveform; asynchronous to clk.
- `note_idx`  out  3  last locked note: 0=C4 … 7=C5.
- `note_valid`  out  1  one-cycle strobe when a note is newly locked.
- `note_locked`  out  1  level; high while in LOCKED.
- `note_err`  out  1  one-cycle strobe when a measured half-period matches no note.
- `silence`  out  1  level; high while in SILENT.

## Operation
**Input path**
- `tone_in` passes through a 2-flop synchronizer, then a delay flop.
- An edge is any difference between the synchronized value and its delayed copy; both polarities count.

**Half-period counter**
- `hp_cnt` is 16 bits. It loads 1 on an edge cycle and otherwise increments, saturating at `SILENCE_CYC`.
- On an edge cycle, the measured half-period is H = `hp_cnt`, i.e. the number of cycles between the two edges.

**Nominal half-periods** (generator period + 1), indices 0–7:
- 1912, 1704, 1518, 1433, 1277, 1137, 1013, 957.

**Classification**
- H matches index i when |H − nom_i| ≤ `TOL`, computed on 17-bit signed arithmetic.
- There is no match otherwise. Ranges do not overlap, so at most one index matches.

**State machine**: SILENT, ACQUIRE, LOCKED. The machine also holds `cand` (3 bits) and `run` (3 bits).
- **SILENT**
  - Outputs: `silence`=1, `note_locked`=0.
  - First edge: go to ACQUIRE with `run`=0. No measurement is taken because H is meaningless.
- **ACQUIRE**
  - On an edge with a match at index i:
    - If i == `cand` and `run` > 0, `run` increments.
    - Otherwise `cand`=i and `run`=1.
  - When `run` reaches `STABLE`: go to LOCKED, `note_idx`=`cand`, pulse `note_valid`.
  - On an edge with a miss: `run`=0 and pulse `note_err`.
- **LOCKED**
  - Match to `note_idx`: stay, no strobe.
  - Match to a different index j: go to ACQUIRE with `cand`=j, `run`=1. `note_locked` drops.
  - Miss: go to ACQUIRE with `run`=0 and pulse `note_err`.
- **Any state except SILENT**: when `hp_cnt` reaches `SILENCE_CYC` with no edge, go to SILENT. This covers a line stuck high or stuck low.
- `note_idx` holds its last locked value through ACQUIRE and SILENT.

## Timing
**Reset values**
- `note_idx`=0, `note_valid`=0, `note_locked`=0, `note_err`=0, `silence`=1.
- State SILENT, `hp_cnt`=0, `cand`=0, `run`=0. Synchronizer flops cleared.

**Latency**
- `note_valid`/`note_err` assert exactly 3 clk edges after the first clk edge that samples the qualifying `tone_in` transition: 2 synchronizer cycles plus 1 registered output.
- Strobes are exactly one cycle wide.
- `note_locked` rises in the same cycle as `note_valid`.

**Edge/timeout precedence**
- An edge on the same cycle that `hp_cnt` would reach `SILENCE_CYC`: the edge wins and a normal measurement is taken.

**Lock time**
- Nominal lock time is (`STABLE`+1) half-periods after the tone starts from silence: the first edge is discarded.
- A note change while LOCKED relocks after `STABLE` half-periods of the new note.

**Reset mid-operation**
- Asserting `rst` forces the reset values immediately.
- After release, a full reacquisition is required.

## Test plan
- **Reset and idle**
  - Stimulus: assert `rst` mid-lock; release; hold `tone_in`=0 for 10000 cycles.
  - Required: all outputs at reset values throughout; no strobes.
- **Single-note lock**
  - Stimulus: after 100 idle cycles, toggle `tone_in` every 1912 cycles.
  - Required: `note_valid` with `note_idx`=0 exactly 3 cycles after the 4th edge; no further strobes over 50 edges; `note_locked`=1.
- **Full scale**
  - Stimulus: play the eight half-periods 1912…957, each held for 500001 cycles.
  - Required: exactly 8 `note_valid` pulses, `note_idx` 0,1,…,7 in order; no `note_err`.
- **Tolerance boundary**
  - Stimulus: half-period 1932 (nom+20).
  - Required: locks to idx 0.
  - Stimulus: half-period 1933 (nom+21).
  - Required: `note_err` on every edge after the first; never locks.
  - Same check at 937/936 for idx 7.
- **Silence**
  - Stimulus: lock on idx 4 (1277); stop toggling.
  - Required: `silence` rises and `note_locked` falls exactly 4096 cycles (+2 sync) after the last edge; `note_idx` stays 4.
- **Glitch while locked**
  - Stimulus: lock on idx 2 (1518); inject one 1600-cycle half-period; then resume 1518.
  - Required: one `note_err`; `note_locked` low; re-lock with `note_valid`, idx 2, after 3 good half-periods.
